zl_pll_supervisor: RTL and testbench

Parametrised PLL bring-up and supervision controller, run on the free-running reference clock ahead of the system PLL. It drives the PLL areset and qualifies lock with a stability window and a lock timeout. It releases N downstream domain resets in a fixed order with a programmable gap, and re-sequences automatically on lock loss or software request. It also keeps saturating lock-loss and timeout counters for status.

---
 rtl/zl_pll_supervisor.sv | 242 ++++++++++++++++++++++++
 tb/tb_zl_pll_supervisor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zl_pll_supervisor.sv
// zl_pll_supervisor
// PLL bring-up and supervision controller on the free-running reference clock.
// It pulses the PLL areset, qualifies lock with a stability window and a
// timeout, and releases the downstream domain resets in order with a fixed gap.
// The sequence restarts on lock loss or on a software request. All outputs are
// registered, and the status counters saturate instead of wrapping.

module zl_pll_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int N_DOMAINS           = 2,
    parameter int RELEASE_GAP_CYCLES  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_lock,
    input  logic                 force_relock,
    output logic                 pll_areset,
    output logic [N_DOMAINS-1:0] domain_rst,
    output logic                 ready,
    output logic [2:0]           state,
    output logic [7:0]           lock_lost_cnt,
    output logic [7:0]           timeout_cnt
);

    // FSM state encodings (visible on the state port)
    localparam logic [2:0] ST_RESET_PLL = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    // Timer widths are sized so that no timer wraps before its terminal count
    localparam int PULSE_W  = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
    localparam int TMO_W    = $clog2(LOCK_TIMEOUT_CYCLES);
    localparam int STB_W    = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int REL_LAST = (N_DOMAINS - 1) * RELEASE_GAP_CYCLES;
    localparam int REL_W    = (REL_LAST > 0) ? $clog2(REL_LAST + 1) : 1;

    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYCLES - 1);
    localparam logic [PULSE_W-1:0] PULSE_ONE  = PULSE_W'(1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_ONE    = TMO_W'(1);
    localparam logic [STB_W-1:0]   STB_LAST   = STB_W'(LOCK_STABLE_CYCLES);
    localparam logic [STB_W-1:0]   STB_ONE    = STB_W'(1);
    localparam logic [REL_W-1:0]   REL_LAST_V = REL_W'(REL_LAST);
    localparam logic [REL_W-1:0]   REL_ONE    = REL_W'(1);

    localparam logic [N_DOMAINS-1:0] DOM_ALL_ON  = {N_DOMAINS{1'b1}};
    localparam logic [N_DOMAINS-1:0] DOM_ALL_OFF = {N_DOMAINS{1'b0}};

    // Saturating 8-bit increment for the status counters
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'h01;
        end
    endfunction

    // Domain reset pattern t cycles into RELEASE: bit i drops at t = i*gap
    function automatic logic [N_DOMAINS-1:0] release_mask(input int t);
        logic [N_DOMAINS-1:0] m;
        m = DOM_ALL_ON;
        for (int i = 0; i < N_DOMAINS; i++) begin
            m[i] = (t < i * RELEASE_GAP_CYCLES) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    // Registers
    logic                 lock_meta_r;
    logic                 lock_sync_r;
    logic [2:0]           state_r;
    logic                 pll_areset_r;
    logic [N_DOMAINS-1:0] domain_rst_r;
    logic                 ready_r;
    logic [PULSE_W-1:0]   pulse_tmr_r;
    logic [TMO_W-1:0]     lock_tmr_r;
    logic [STB_W-1:0]     stable_cnt_r;
    logic [REL_W-1:0]     rel_tmr_r;
    logic [7:0]           lost_cnt_r;
    logic [7:0]           tmo_cnt_r;

    // Next-state values
    logic [2:0]           state_s;
    logic                 pll_areset_s;
    logic [N_DOMAINS-1:0] domain_rst_s;
    logic                 ready_s;
    logic [PULSE_W-1:0]   pulse_tmr_s;
    logic [TMO_W-1:0]     lock_tmr_s;
    logic [STB_W-1:0]     stable_cnt_s;
    logic [REL_W-1:0]     rel_tmr_s;
    logic [7:0]           lost_cnt_s;
    logic [7:0]           tmo_cnt_s;

    // Two-flop synchroniser for the asynchronous PLL lock indication
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Sequencer next-state logic; force_relock overrides every other transition
    always_comb begin
        state_s      = state_r;
        pll_areset_s = pll_areset_r;
        domain_rst_s = domain_rst_r;
        ready_s      = 1'b0;
        pulse_tmr_s  = pulse_tmr_r;
        lock_tmr_s   = lock_tmr_r;
        stable_cnt_s = stable_cnt_r;
        rel_tmr_s    = rel_tmr_r;
        lost_cnt_s   = lost_cnt_r;
        tmo_cnt_s    = tmo_cnt_r;

        if (force_relock) begin
            state_s      = ST_RESET_PLL;
            pll_areset_s = 1'b1;
            domain_rst_s = DOM_ALL_ON;
            pulse_tmr_s  = {PULSE_W{1'b0}};
        end else begin
            case (state_r)
                ST_RESET_PLL: begin
                    domain_rst_s = DOM_ALL_ON;
                    if (pulse_tmr_r == PULSE_LAST) begin
                        state_s      = ST_WAIT_LOCK;
                        pll_areset_s = 1'b0;
                        pulse_tmr_s  = {PULSE_W{1'b0}};
                        lock_tmr_s   = {TMO_W{1'b0}};
                    end else begin
                        pll_areset_s = 1'b1;
                        pulse_tmr_s  = pulse_tmr_r + PULSE_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    domain_rst_s = DOM_ALL_ON;
                    if (lock_sync_r) begin
                        state_s      = ST_STABLE;
                        stable_cnt_s = {STB_W{1'b0}};
                    end else if (lock_tmr_r == TMO_LAST) begin
                        state_s      = ST_RESET_PLL;
                        pll_areset_s = 1'b1;
                        pulse_tmr_s  = {PULSE_W{1'b0}};
                        tmo_cnt_s    = sat_inc8(tmo_cnt_r);
                    end else begin
                        lock_tmr_s = lock_tmr_r + TMO_ONE;
                    end
                end
                ST_STABLE: begin
                    // Any lock drop ends the window; a glitch here is not a lock loss
                    if (!lock_sync_r) begin
                        state_s    = ST_WAIT_LOCK;
                        lock_tmr_s = {TMO_W{1'b0}};
                    end else if (stable_cnt_r == STB_LAST) begin
                        state_s      = ST_RELEASE;
                        rel_tmr_s    = {REL_W{1'b0}};
                        domain_rst_s = release_mask(32'sd0);
                    end else begin
                        stable_cnt_s = stable_cnt_r + STB_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (!lock_sync_r) begin
                        state_s      = ST_RESET_PLL;
                        pll_areset_s = 1'b1;
                        domain_rst_s = DOM_ALL_ON;
                        pulse_tmr_s  = {PULSE_W{1'b0}};
                        lost_cnt_s   = sat_inc8(lost_cnt_r);
                    end else if (rel_tmr_r == REL_LAST_V) begin
                        state_s      = ST_RUN;
                        domain_rst_s = DOM_ALL_OFF;
                        ready_s      = 1'b1;
                    end else begin
                        rel_tmr_s    = rel_tmr_r + REL_ONE;
                        domain_rst_s = release_mask(int'(rel_tmr_r) + 32'sd1);
                    end
                end
                ST_RUN: begin
                    if (!lock_sync_r) begin
                        state_s      = ST_RESET_PLL;
                        pll_areset_s = 1'b1;
                        domain_rst_s = DOM_ALL_ON;
                        pulse_tmr_s  = {PULSE_W{1'b0}};
                        lost_cnt_s   = sat_inc8(lost_cnt_r);
                    end else begin
                        pll_areset_s = 1'b0;
                        domain_rst_s = DOM_ALL_OFF;
                        ready_s      = 1'b1;
                    end
                end
                default: begin
                    // Unreachable encodings recover through a full reset sequence
                    state_s      = ST_RESET_PLL;
                    pll_areset_s = 1'b1;
                    domain_rst_s = DOM_ALL_ON;
                    pulse_tmr_s  = {PULSE_W{1'b0}};
                end
            endcase
        end
    end

    // Sequencer state, output and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_RESET_PLL;
            pll_areset_r <= 1'b1;
            domain_rst_r <= DOM_ALL_ON;
            ready_r      <= 1'b0;
            pulse_tmr_r  <= {PULSE_W{1'b0}};
            lock_tmr_r   <= {TMO_W{1'b0}};
            stable_cnt_r <= {STB_W{1'b0}};
            rel_tmr_r    <= {REL_W{1'b0}};
            lost_cnt_r   <= 8'h00;
            tmo_cnt_r    <= 8'h00;
        end else begin
            state_r      <= state_s;
            pll_areset_r <= pll_areset_s;
            domain_rst_r <= domain_rst_s;
            ready_r      <= ready_s;
            pulse_tmr_r  <= pulse_tmr_s;
            lock_tmr_r   <= lock_tmr_s;
            stable_cnt_r <= stable_cnt_s;
            rel_tmr_r    <= rel_tmr_s;
            lost_cnt_r   <= lost_cnt_s;
            tmo_cnt_r    <= tmo_cnt_s;
        end
    end

    assign state         = state_r;
    assign pll_areset    = pll_areset_r;
    assign domain_rst    = domain_rst_r;
    assign ready         = ready_r;
    assign lock_lost_cnt = lost_cnt_r;
    assign timeout_cnt   = tmo_cnt_r;

endmodule

// File: tb/tb_zl_pll_supervisor.sv
// Testbench for zl_pll_supervisor: directed scenarios and randomized lock,
// relock and reset traffic. Each cycle is checked against a phase/age
// reference model of the sequencing rules.

module tb_zl_pll_supervisor;

    localparam int P   = 4;
    localparam int LS  = 8;
    localparam int TO  = 32;
    localparam int ND  = 3;
    localparam int GAP = 2;

    localparam int M_RESET   = 0;
    localparam int M_WAIT    = 1;
    localparam int M_STABLE  = 2;
    localparam int M_RELEASE = 3;
    localparam int M_RUN     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_lock;
    logic          force_relock;
    logic          pll_areset;
    logic [ND-1:0] domain_rst;
    logic          ready;
    logic [2:0]    state;
    logic [7:0]    lock_lost_cnt;
    logic [7:0]    timeout_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: the current phase and the cycles spent in it
    int   mode;
    int   age;
    int   exp_lost;
    int   exp_tmo;
    logic sync_q[$];

    always #5 clk = ~clk;

    zl_pll_supervisor #(
        .RST_PULSE_CYCLES   (P),
        .LOCK_STABLE_CYCLES (LS),
        .LOCK_TIMEOUT_CYCLES(TO),
        .N_DOMAINS          (ND),
        .RELEASE_GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .force_relock (force_relock),
        .pll_areset   (pll_areset),
        .domain_rst   (domain_rst),
        .ready        (ready),
        .state        (state),
        .lock_lost_cnt(lock_lost_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic enter(input int m);
        mode = m;
        age  = 0;
    endtask

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // Advance the model by one rising edge using the inputs present at that edge
    task automatic model_edge();
        logic ls;
        if (rst) begin
            enter(M_RESET);
            exp_lost = 0;
            exp_tmo  = 0;
            sync_q   = '{1'b0, 1'b0};
        end else begin
            ls = sync_q.pop_front();
            sync_q.push_back(pll_lock);
            if (force_relock) begin
                enter(M_RESET);
            end else begin
                case (mode)
                    M_RESET:   if (age == P - 1) enter(M_WAIT); else age++;
                    M_WAIT: begin
                        if (ls) enter(M_STABLE);
                        else if (age == TO - 1) begin enter(M_RESET); exp_tmo = sat(exp_tmo); end
                        else age++;
                    end
                    M_STABLE: begin
                        if (!ls) enter(M_WAIT);
                        else if (age == LS) enter(M_RELEASE);
                        else age++;
                    end
                    M_RELEASE: begin
                        if (!ls) begin enter(M_RESET); exp_lost = sat(exp_lost); end
                        else if (age == (ND - 1) * GAP) enter(M_RUN);
                        else age++;
                    end
                    M_RUN: if (!ls) begin enter(M_RESET); exp_lost = sat(exp_lost); end
                    default: enter(M_RESET);
                endcase
            end
        end
    endtask

    task automatic check_outputs();
        logic [ND-1:0] exp_dom;
        for (int i = 0; i < ND; i++) begin
            exp_dom[i] = !(mode == M_RUN || (mode == M_RELEASE && age >= i * GAP));
        end
        check_eq("state",         32'(state),         32'(mode));
        check_eq("pll_areset",    32'(pll_areset),    32'(mode == M_RESET));
        check_eq("domain_rst",    32'(domain_rst),    32'(exp_dom));
        check_eq("ready",         32'(ready),         32'(mode == M_RUN));
        check_eq("lock_lost_cnt", 32'(lock_lost_cnt), 32'(exp_lost));
        check_eq("timeout_cnt",   32'(timeout_cnt),   32'(exp_tmo));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Step until the model reaches phase m with at least age a, within a budget
    task automatic wait_phase(input string tag, input int m, input int a, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (mode == m && age >= a) break;
            tick();
        end
        check_eq(tag, 32'(state), 32'(m));
    endtask

    int n_ticks;
    int lost_before;
    int tmo_before;
    int seg;
    logic lvl;

    initial begin
        rst          = 1'b1;
        pll_lock     = 1'b0;
        force_relock = 1'b0;
        sync_q       = '{1'b0, 1'b0};
        enter(M_RESET);
        exp_lost = 0;
        exp_tmo  = 0;
        repeat (3) tick();

        // Bring-up with lock held high: fixed latency to ready
        rst      = 1'b0;
        pll_lock = 1'b1;
        n_ticks  = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            n_ticks++;
            if (n_ticks == 14) check_eq("first_release", 32'(domain_rst), 32'b110);
            if (ready === 1'b1) break;
        end
        check_eq("ready_latency", 32'(n_ticks), 32'd19);

        // Lock never arrives: repeated timeouts, counter saturates at 255
        pll_lock = 1'b0;
        repeat (300 * (P + TO) + 20) tick();
        check_eq("timeout_sat", 32'(timeout_cnt), 32'd255);

        // One-cycle lock drop in RUN
        pll_lock = 1'b1;
        wait_phase("reach_run1", M_RUN, 0, 200);
        lost_before = exp_lost;
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        tick();
        check_eq("drop_dom", 32'(domain_rst), 32'b111);
        check_eq("drop_ready", 32'(ready), 32'd0);
        check_eq("drop_lost", 32'(lock_lost_cnt), 32'(lost_before + 1));
        wait_phase("reach_run2", M_RUN, 0, 200);

        // Glitch in STABLE: back to WAIT_LOCK, no counter change
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        wait_phase("reach_stable", M_STABLE, 3, 200);
        lost_before = exp_lost;
        tmo_before  = exp_tmo;
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        tick();
        check_eq("glitch_state", 32'(state), 32'(M_WAIT));
        wait_phase("reach_release", M_RELEASE, 1, 200);
        check_eq("glitch_lost", 32'(lock_lost_cnt), 32'(lost_before));
        check_eq("glitch_tmo", 32'(timeout_cnt), 32'(tmo_before));

        // force_relock during RELEASE after bit 0 was released
        lost_before = exp_lost;
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        check_eq("force_dom", 32'(domain_rst), 32'b111);
        check_eq("force_areset", 32'(pll_areset), 32'd1);
        repeat (P - 1) tick();
        check_eq("force_pulse_end", 32'(pll_areset), 32'd1);
        tick();
        check_eq("force_pulse_off", 32'(pll_areset), 32'd0);
        check_eq("force_lost", 32'(lock_lost_cnt), 32'(lost_before));

        // rst while in RUN clears everything
        wait_phase("reach_run3", M_RUN, 0, 200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_lost", 32'(lock_lost_cnt), 32'd0);
        check_eq("rst_tmo", 32'(timeout_cnt), 32'd0);
        check_eq("rst_dom", 32'(domain_rst), 32'b111);
        wait_phase("reach_run4", M_RUN, 0, 200);

        // Randomized lock segments with occasional relock requests and resets
        lvl = 1'b1;
        seg = 0;
        for (int c = 0; c < 5000; c++) begin
            if (seg == 0) begin
                lvl = ~lvl;
                seg = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
            end
            seg--;
            pll_lock     = lvl;
            force_relock = ($urandom_range(0, 199) == 0);
            rst          = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst          = 1'b0;
        force_relock = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
